// File: rtl/rv32i_opcodes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_opcodes (package)
// Purpose  : Shared encodings for the rv32i core: write-back source select,
//            load size, and the write-back stage state encoding.
// Contents : wb_src_t   - WB_ALU / WB_MEM / WB_PC4 / WB_CSR (2-bit)
//            ld_size_t  - LD_B / LD_H / LD_W (2-bit, 2'b11 reserved -> word)
//            wb_state_t - IDLE / WAIT_MEM (1-bit)
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_opcodes;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_CSR = 2'b11
    } wb_src_t;

    // Encoding 2'b11 is reserved; consumers decode it as a word load.
    typedef enum logic [1:0] {
        LD_B = 2'b00,
        LD_H = 2'b01,
        LD_W = 2'b10
    } ld_size_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

endpackage : rv32i_opcodes
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Purpose  : Combinational sub-word extraction and sign/zero extension of
//            aligned-word load data. Shared by the register write path and
//            the early-forwarding path of wb_stage.
// Ports    : i_raw    [WIDTH]  raw aligned-word load data
//            i_size   ld_size_t  LD_B / LD_H / LD_W (reserved -> word)
//            i_signed           1 = sign-extend, 0 = zero-extend
//            i_off    [2]       byte offset (address bits [1:0])
//            o_ext    [WIDTH]   extended result
// Revision : 1.0 - initial release
// ============================================================================
module load_extend
    import rv32i_opcodes::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_raw,
    input  ld_size_t         i_size,
    input  logic             i_signed,
    input  logic [1:0]       i_off,
    output logic [WIDTH-1:0] o_ext
);

    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [WIDTH-1:0] w_word_ext;

    // Word loads ignore the offset; on a 64-bit datapath the low word is
    // extended, on a 32-bit datapath it passes through untouched.
    generate
        if (WIDTH == 32) begin : g_word32
            assign w_word_ext = i_raw[31:0];
        end else begin : g_word64
            assign w_word_ext = {{(WIDTH-32){i_signed & i_raw[31]}}, i_raw[31:0]};
        end
    endgenerate

    always_comb begin
        w_byte = i_raw[7:0];
        case (i_off)
            2'd1:    w_byte = i_raw[15:8];
            2'd2:    w_byte = i_raw[23:16];
            2'd3:    w_byte = i_raw[31:24];
            default: w_byte = i_raw[7:0];
        endcase
        // Halfword uses only off[1]; a misaligned off[0] is ignored.
        w_half = i_off[1] ? i_raw[31:16] : i_raw[15:0];

        case (i_size)
            LD_B:    o_ext = {{(WIDTH-8){i_signed & w_byte[7]}}, w_byte};
            LD_H:    o_ext = {{(WIDTH-16){i_signed & w_half[15]}}, w_half};
            default: o_ext = w_word_ext;
        endcase
    end

endmodule : load_extend
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Registered, handshaked register-file write-back stage. Accepts
//            one retiring instruction per cycle, selects ALU / PC+4 / CSR
//            results directly, or waits for a load response and extends it.
// Ports    : clk, rst_n (synchronous, active-low)
//            in_valid/in_ready handshake; in_rd, in_src, in_ld_size,
//            in_ld_signed, in_byte_off, alu_out, pc_plus4, csr_rd_data
//            mem_rsp_valid, mem_rd_data  - load response
//            rf_wr_en/rf_wr_addr/rf_wr_data - registered RF write port
//            busy (load outstanding), stray_rsp (sticky unexpected response)
//            fwd_valid/fwd_rd/fwd_data - forwarding bus (WB_FWD_EN only)
// Config   : define WB_FWD_EN to add the forwarding bus.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage
    import rv32i_opcodes::*;
#(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] in_rd,
    input  wb_src_t            in_src,
    input  ld_size_t           in_ld_size,
    input  logic               in_ld_signed,
    input  logic [1:0]         in_byte_off,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic [WIDTH-1:0]   pc_plus4,
    input  logic [WIDTH-1:0]   csr_rd_data,
    input  logic               mem_rsp_valid,
    input  logic [WIDTH-1:0]   mem_rd_data,
    output logic               rf_wr_en,
    output logic [RADDR_W-1:0] rf_wr_addr,
    output logic [WIDTH-1:0]   rf_wr_data,
    output logic               busy,
    output logic               stray_rsp
`ifdef WB_FWD_EN
    ,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [WIDTH-1:0]   fwd_data
`endif
);

    wb_state_t          r_state;
    wb_state_t          w_state_nxt;

    logic [RADDR_W-1:0] r_ld_rd;
    ld_size_t           r_ld_size;
    logic               r_ld_signed;
    logic [1:0]         r_ld_off;

    logic               r_wr_en;
    logic [RADDR_W-1:0] r_wr_addr;
    logic [WIDTH-1:0]   r_wr_data;
    logic               r_stray;

    logic               w_accept;
    logic               w_rsp_take;
    logic [WIDTH-1:0]   w_src_sel;
    logic [WIDTH-1:0]   w_ld_ext;

    // Ready is gated by rst_n so nothing is accepted in the reset cycle.
    assign in_ready   = (r_state == IDLE) && rst_n;
    assign busy       = (r_state == WAIT_MEM);
    assign w_accept   = in_valid && in_ready;
    assign w_rsp_take = (r_state == WAIT_MEM) && mem_rsp_valid;

    always_comb begin
        w_src_sel = alu_out;
        case (in_src)
            WB_PC4:  w_src_sel = pc_plus4;
            WB_CSR:  w_src_sel = csr_rd_data;
            default: w_src_sel = alu_out;
        endcase
    end

    load_extend #(
        .WIDTH    (WIDTH)
    ) u_load_extend (
        .i_raw    (mem_rd_data),
        .i_size   (r_ld_size),
        .i_signed (r_ld_signed),
        .i_off    (r_ld_off),
        .o_ext    (w_ld_ext)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_accept && (in_src == WB_MEM)) w_state_nxt = WAIT_MEM;
            WAIT_MEM: if (mem_rsp_valid)                  w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // ---------------- load context ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ld_rd     <= '0;
            r_ld_size   <= LD_B;
            r_ld_signed <= 1'b0;
            r_ld_off    <= 2'b00;
        end else if (w_accept && (in_src == WB_MEM)) begin
            r_ld_rd     <= in_rd;
            r_ld_size   <= in_ld_size;
            r_ld_signed <= in_ld_signed;
            r_ld_off    <= in_byte_off;
        end
    end

    // ---------------- registered write port ----------------
    // Writes to x0 still complete the handshake but never strobe the RF.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_accept && (in_src != WB_MEM)) begin
                r_wr_en   <= (in_rd != '0);
                r_wr_addr <= in_rd;
                r_wr_data <= w_src_sel;
            end else if (w_rsp_take) begin
                r_wr_en   <= (r_ld_rd != '0);
                r_wr_addr <= r_ld_rd;
                r_wr_data <= w_ld_ext;
            end
        end
    end

    // A response seen in IDLE (including the accept cycle of a load, or
    // one arriving after a reset dropped the pending load) is flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stray <= 1'b0;
        end else if ((r_state == IDLE) && mem_rsp_valid) begin
            r_stray <= 1'b1;
        end
    end

    assign rf_wr_en   = r_wr_en;
    assign rf_wr_addr = r_wr_addr;
    assign rf_wr_data = r_wr_data;
    assign stray_rsp  = r_stray;

`ifdef WB_FWD_EN
    // Early bypass: in the response cycle the extended load data is put on
    // the bus before it is registered; otherwise the bus mirrors the write.
    logic w_fwd_early;
    assign w_fwd_early = w_rsp_take && rst_n && (r_ld_rd != '0);
    assign fwd_valid   = r_wr_en || w_fwd_early;
    assign fwd_rd      = w_fwd_early ? r_ld_rd  : r_wr_addr;
    assign fwd_data    = w_fwd_early ? w_ld_ext : r_wr_data;
`endif

endmodule : wb_stage
`default_nettype wire
